// File: rtl/timer_arbiter_pkg.sv
// Shared types and defaults for the round-robin shared-counter scheduler.
package timer_arbiter_pkg;

  parameter int unsigned NumReqDefault   = 4;
  parameter int unsigned CntWidthDefault = 3;

  typedef logic [1:0] ta_state_e;

  localparam ta_state_e StIdle = 2'd0;
  localparam ta_state_e StLoad = 2'd1;
  localparam ta_state_e StRun  = 2'd2;
  localparam ta_state_e StDone = 2'd3;

endpackage

// File: rtl/timer_arbiter_if.sv
// Requester-side bundle of the timer arbiter: requests and targets in, grant/done/status out.
interface timer_arbiter_if
  import timer_arbiter_pkg::*;
#(
  parameter int unsigned NumReq   = NumReqDefault,
  parameter int unsigned CntWidth = CntWidthDefault
);

  logic [NumReq-1:0]          req;
  logic [NumReq*CntWidth-1:0] req_count;
  logic                       tick;
  logic [NumReq-1:0]          grant;
  logic [NumReq-1:0]          done;
  logic                       busy;
  logic [CntWidth-1:0]        count;

  modport master (
    output req, req_count, tick,
    input  grant, done, busy, count
  );

  modport slave (
    input  req, req_count, tick,
    output grant, done, busy, count
  );

endinterface

// File: rtl/timer_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned  NumReq = 4,
  localparam int unsigned PtrW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [PtrW-1:0]   rr_ptr_i,
  output logic [NumReq-1:0] winner_o,
  output logic [PtrW-1:0]   winner_idx_o
);

  int unsigned pick_idx;
  logic        found;

  always_comb begin
    winner_o     = '0;
    winner_idx_o = '0;
    found        = 1'b0;
    pick_idx     = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      pick_idx = (32'(rr_ptr_i) + k) % NumReq;
      if (!found && req_i[pick_idx]) begin
        found                  = 1'b1;
        winner_o[pick_idx]     = 1'b1;
        winner_idx_o           = PtrW'(pick_idx);
      end
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// Shares one tick counter among NumReq requesters: round-robin grant, count to target, pulse done.
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int unsigned  NumReq   = NumReqDefault,
  parameter int unsigned  CntWidth = CntWidthDefault,
  localparam int unsigned PtrW     = $clog2(NumReq)
) (
  input  logic            clk_i,
  input  logic            clr_i,
  timer_arbiter_if.slave  bus
);

  ta_state_e           state_q, state_d;
  logic [NumReq-1:0]   grant_q, grant_d;
  logic [PtrW-1:0]     idx_q, idx_d;
  logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CntWidth-1:0] limit_q, limit_d;
  logic [CntWidth-1:0] count_q, count_d;

  logic [NumReq-1:0]   winner;
  logic [PtrW-1:0]     winner_idx;
  logic [CntWidth-1:0] target;
  logic [CntWidth-1:0] count_inc;

  rr_pick #(
    .NumReq (NumReq)
  ) u_rr_pick (
    .req_i        (bus.req),
    .rr_ptr_i     (rr_ptr_q),
    .winner_o     (winner),
    .winner_idx_o (winner_idx)
  );

  always_comb begin
    target = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (idx_q == PtrW'(i)) target = bus.req_count[i*CntWidth +: CntWidth];
    end
  end

  assign count_inc = count_q + CntWidth'(1);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    limit_d  = limit_q;
    count_d  = count_q;
    case (state_q)
      StIdle: begin
        if (|bus.req) begin
          grant_d = winner;
          idx_d   = winner_idx;
          state_d = StLoad;
        end
      end
      StLoad: begin
        limit_d = target;
        count_d = '0;
        state_d = (target == '0) ? StDone : StRun;
      end
      StRun: begin
        // A dropped request wins over a same-cycle tick and leaves rr_ptr alone.
        if (!bus.req[idx_q]) begin
          grant_d = '0;
          state_d = StIdle;
        end else if (bus.tick) begin
          count_d = count_inc;
          if (count_inc == limit_q) state_d = StDone;
        end
      end
      StDone: begin
        rr_ptr_d = (idx_q == PtrW'(NumReq - 1)) ? '0 : idx_q + PtrW'(1);
        grant_d  = '0;
        state_d  = StIdle;
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      limit_q  <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      limit_q  <= limit_d;
      count_q  <= count_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = (state_q == StDone) ? grant_q : '0;
  assign bus.busy  = (state_q != StIdle);
  assign bus.count = count_q;

endmodule
